// File: rtl/demo_frame_parser.sv
// Byte-stream frame parser: SYNC, LEN, LEN payload bytes, CSUM -> payload stream plus per-frame status.
// Define DEMO_FRAME_PARSER_STATS_EN to build the saturating good/bad frame counters.
module demo_frame_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 64,
    parameter int         TIMEOUT   = 16,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             frm_done,
    output logic             frm_ok,
    output logic [1:0]       frm_err,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAY, S_CSUM} state_t;

    localparam int           TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]   MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    acc_q, acc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          frm_done_q, frm_done_d;
    logic          frm_ok_q, frm_ok_d;
    logic [1:0]    frm_err_q, frm_err_d;

    logic       in_beat;
    logic       out_beat;
    logic [7:0] acc_sum;

    always_comb begin
        s_ready    = (state_q == S_PAY) ? (!m_valid_q || m_ready) : 1'b1;
        in_beat    = s_valid && s_ready;
        out_beat   = m_valid_q && m_ready;
        acc_sum    = acc_q + s_data;

        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        tmo_d      = tmo_q;
        m_valid_d  = m_valid_q && !m_ready;
        m_data_d   = m_data_q;
        m_last_d   = out_beat ? 1'b0 : m_last_q;
        frm_done_d = 1'b0;
        frm_ok_d   = 1'b0;
        frm_err_d  = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (in_beat && s_data == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (in_beat) begin
                    len_d = s_data;
                    acc_d = s_data;
                    if (s_data == 8'd0) begin
                        state_d = S_CSUM;
                    end else if (s_data > MAX_LEN_B) begin
                        frm_done_d = 1'b1;
                        frm_err_d  = 2'd2;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (in_beat) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (len_q == 8'd1);
                    acc_d     = acc_sum;
                    len_d     = len_q - 8'd1;
                    if (len_q == 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (in_beat) begin
                    frm_done_d = 1'b1;
                    frm_ok_d   = (acc_sum == 8'd0);
                    frm_err_d  = (acc_sum == 8'd0) ? 2'd0 : 2'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle cycles mid-frame count toward the abort; backpressure stalls do not.
        if (state_q == S_IDLE || in_beat) begin
            tmo_d = '0;
        end else if (!s_valid) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d      = '0;
                frm_done_d = 1'b1;
                frm_err_d  = 2'd3;
                state_d    = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 8'd0;
            acc_q      <= 8'd0;
            tmo_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'd0;
            m_last_q   <= 1'b0;
            frm_done_q <= 1'b0;
            frm_ok_q   <= 1'b0;
            frm_err_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            frm_done_q <= frm_done_d;
            frm_ok_q   <= frm_ok_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign frm_done = frm_done_q;
    assign frm_ok   = frm_ok_q;
    assign frm_err  = frm_err_q;

`ifdef DEMO_FRAME_PARSER_STATS_EN
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;

    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (stat_clr) begin
            good_d = '0;
            bad_d  = '0;
        end else if (frm_done_q) begin
            if (frm_ok_q && good_q != '1) good_d = good_q + CNT_W'(1);
            if (!frm_ok_q && bad_q != '1) bad_d = bad_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign good_cnt = '0;
    assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_demo_frame_parser.sv
// Scoreboard bench for demo_frame_parser: expected payload and status are queued as frames are driven.
module tb_demo_frame_parser;

    localparam int         MAX_LEN = 64;
    localparam int         TIMEOUT = 16;
    localparam int         CNT_W   = 16;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic             clk;
    logic             rst_n;
    logic             s_valid, s_ready;
    logic [7:0]       s_data;
    logic             m_valid, m_ready, m_last;
    logic [7:0]       m_data;
    logic             frm_done, frm_ok;
    logic [1:0]       frm_err;
    logic             stat_clr;
    logic [CNT_W-1:0] good_cnt, bad_cnt;

    demo_frame_parser #(
        .SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frm_done(frm_done), .frm_ok(frm_ok), .frm_err(frm_err),
        .stat_clr(stat_clr), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_good = 0;
    int exp_bad  = 0;
    int rmode    = 0;

    logic [8:0] pq[$];   // {last, data}
    logic [2:0] sq[$];   // {ok, err}
    logic [7:0] pay[$];

    // Downstream ready: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    initial begin
        int ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every payload beat and status strobe.
    initial begin
        logic       hold_pend = 1'b0;
        logic [7:0] hold_d = 8'd0;
        logic       hold_l = 1'b0;
        logic [8:0] ep;
        logic [2:0] es;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    checks++;
                    if (!m_valid || m_data !== hold_d || m_last !== hold_l) begin
                        failures++;
                        $display("FAIL stall_hold got v=%0b d=%02h l=%0b exp v=1 d=%02h l=%0b",
                                 m_valid, m_data, m_last, hold_d, hold_l);
                    end
                end
                hold_pend = m_valid && !m_ready;
                hold_d    = m_data;
                hold_l    = m_last;
                if (m_valid && m_ready) begin
                    checks++;
                    if (pq.size() == 0) begin
                        failures++;
                        $display("FAIL payload_extra got d=%02h l=%0b exp none", m_data, m_last);
                    end else begin
                        ep = pq.pop_front();
                        if ({m_last, m_data} !== ep) begin
                            failures++;
                            $display("FAIL payload got d=%02h l=%0b exp d=%02h l=%0b",
                                     m_data, m_last, ep[7:0], ep[8]);
                        end
                    end
                end
                if (frm_done) begin
                    checks++;
                    if (sq.size() == 0) begin
                        failures++;
                        $display("FAIL status_extra got ok=%0b err=%0d exp none", frm_ok, frm_err);
                    end else begin
                        es = sq.pop_front();
                        if ({frm_ok, frm_err} !== es) begin
                            failures++;
                            $display("FAIL status got ok=%0b err=%0d exp ok=%0b err=%0d",
                                     frm_ok, frm_err, es[2], es[1:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int   n = 0;
        logic got = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        while (!got && n < 200) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_wait got s_ready=0 for %0d cycles exp accept", n);
        end
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] len);
        logic [7:0] s = len;
        foreach (pay[i]) s += pay[i];
        return 8'h00 - s;
    endfunction

    // Drives one frame from the global pay queue and queues its expected outcome.
    task automatic frame(input logic [7:0] len, input logic [7:0] csum);
        logic [7:0] s;
        send(SYNC);
        send(len);
        if (len > 8'(MAX_LEN)) begin
            sq.push_back({1'b0, 2'd2});
            exp_bad++;
            return;
        end
        s = len;
        for (int i = 0; i < int'(len); i++) begin
            s += pay[i];
            pq.push_back({1'(i == int'(len) - 1), pay[i]});
        end
        s += csum;
        if (s == 8'd0) begin
            sq.push_back({1'b1, 2'd0});
            exp_good++;
        end else begin
            sq.push_back({1'b0, 2'd1});
            exp_bad++;
        end
        for (int i = 0; i < int'(len); i++) send(pay[i]);
        send(csum);
    endtask

    task automatic check_stats(input string tag);
        int eg, eb;
`ifdef DEMO_FRAME_PARSER_STATS_EN
        eg = exp_good;
        eb = exp_bad;
`else
        eg = 0;
        eb = 0;
`endif
        checks++;
        if (good_cnt !== CNT_W'(eg) || bad_cnt !== CNT_W'(eb)) begin
            failures++;
            $display("FAIL stats_%s got good=%0d bad=%0d exp good=%0d bad=%0d",
                     tag, good_cnt, bad_cnt, eg, eb);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((pq.size() != 0 || sq.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (pq.size() != 0 || sq.size() != 0) begin
            failures++;
            $display("FAIL drain_%s got pending payload=%0d status=%0d exp 0 0",
                     tag, pq.size(), sq.size());
        end
        repeat (3) @(posedge clk);
        #1;
        check_stats(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'd0 ||
            frm_done !== 1'b0 || frm_ok !== 1'b0 || frm_err !== 2'd0 ||
            good_cnt !== '0 || bad_cnt !== '0) begin
            failures++;
            $display("FAIL %s got rdy=%0b v=%0b l=%0b d=%02h done=%0b ok=%0b err=%0d g=%0d b=%0d exp rdy=1 rest 0",
                     tag, s_ready, m_valid, m_last, m_data, frm_done, frm_ok, frm_err, good_cnt, bad_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; stat_clr = 1'b0;
        #2;
        check_reset_outputs("reset_state");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_reset");
    endtask

    task automatic test_good();
        pay.delete();
        pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
        frame(8'd3, csum_of(8'd3));
        drain("good");
    endtask

    task automatic test_bad_csum();
        pay.delete();
        pay.push_back(8'h10); pay.push_back(8'h20);
        frame(8'd2, 8'h00);
        drain("bad_csum");
    endtask

    task automatic test_over_len();
        pay.delete();
        frame(8'h41, 8'h00);
        frame(8'h00, 8'h00);
        drain("over_len");
    endtask

    task automatic test_max_len();
        pay.delete();
        for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'(i * 7 + 3));
        frame(8'(MAX_LEN), csum_of(8'(MAX_LEN)));
        drain("max_len");
    endtask

    task automatic test_backpressure();
        rmode = 1;
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'(8'h40 + i));
        frame(8'd8, csum_of(8'd8));
        drain("backpressure");
        rmode = 0;
    endtask

    task automatic test_timeout();
        send(SYNC);
        send(8'h04);
        pq.push_back({1'b0, 8'hAA});
        sq.push_back({1'b0, 2'd3});
        exp_bad++;
        send(8'hAA);
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
        pay.delete();
        frame(8'h00, 8'h00);
        drain("timeout");
    endtask

    task automatic test_junk();
        send(8'h00); send(8'hFF); send(8'hA4);
        pay.delete();
        pay.push_back(8'h7E);
        frame(8'h01, csum_of(8'h01));
        drain("junk");
    endtask

    task automatic test_back_to_back();
        rmode = 2;
        for (int f = 0; f < 6; f++) begin
            logic [7:0] l, c;
            pay.delete();
            l = 8'($urandom_range(0, 10));
            for (int i = 0; i < int'(l); i++) pay.push_back(8'($urandom_range(0, 255)));
            c = csum_of(l);
            if ($urandom_range(0, 1) == 1) c = c ^ 8'h5A;
            frame(l, c);
        end
        drain("back_to_back");
        rmode = 0;
    endtask

    task automatic test_stats_clear();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        check_stats("clear");
        pay.delete();
        frame(8'h00, 8'h00);
        drain("after_clear");
    endtask

    task automatic test_reset_mid();
        pay.delete();
        pay.push_back(8'h01);
        frame(8'h00, 8'h01);
        drain("pre_reset");
        send(SYNC);
        send(8'h05);
        pq.push_back({1'b0, 8'h01});
        pq.push_back({1'b0, 8'h02});
        send(8'h01);
        send(8'h02);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_frame");
        pq.delete();
        sq.delete();
        exp_good = 0;
        exp_bad  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pay.delete();
        pay.push_back(8'h5C);
        frame(8'h01, csum_of(8'h01));
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_csum();
        test_over_len();
        test_max_len();
        test_backpressure();
        test_timeout();
        test_junk();
        test_back_to_back();
        test_stats_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
